// File: rtl/reg_dump_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_pkg
// Shared constants and the sequencer state type for the register-dump UART
// transmitter. The CHK state only exists when REG_DUMP_CHKSUM_EN is defined.
// -----------------------------------------------------------------------------
package reg_dump_pkg;

    localparam logic [7:0] HDR_BYTE      = 8'hA5;
    localparam int         NUM_REGS      = 32;
    localparam int         BYTES_PER_REG = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        FETCH = 3'd2,
        SEND  = 3'd3,
`ifdef REG_DUMP_CHKSUM_EN
        CHK   = 3'd4,
`endif
        FIN   = 3'd5
    } state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serialises one byte as 8N1 (start 0, 8 data bits LSB first, stop 1), each
// bit lasting exactly CLKS_PER_BIT clocks. The line idles high.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   load   in   accept data when ready is high
//   data   in   byte to send
//   tx     out  serial line (registered)
//   ready  out  high when a load is accepted this cycle
//
// ready is also high during the final clock of the stop bit, so a byte loaded
// then starts its start bit immediately with no idle gap.
// -----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

    logic        active_q, active_d;
    logic [15:0] clkCnt_q, clkCnt_d;
    logic [3:0]  bitIdx_q, bitIdx_d;
    logic [8:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        bitDone;

    assign bitDone = (clkCnt_q == LAST_CLK);
    assign ready   = !active_q || (bitIdx_q == 4'd9 && bitDone);
    assign tx      = tx_q;

    // Bit timing: bitIdx 0 is the start bit, 1..8 data, 9 the stop bit.
    // The shift register carries data plus the stop bit so tx always takes
    // shift_q[0] when moving to the next bit.
    always_comb begin
        active_d = active_q;
        clkCnt_d = clkCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (active_q) begin
            if (bitDone) begin
                clkCnt_d = '0;
                if (bitIdx_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bitIdx_d = bitIdx_q + 4'd1;
                    tx_d     = shift_q[0];
                    shift_d  = {1'b1, shift_q[8:1]};
                end
            end else begin
                clkCnt_d = clkCnt_q + 16'd1;
            end
        end
        if (load && ready) begin
            active_d = 1'b1;
            clkCnt_d = '0;
            bitIdx_d = '0;
            shift_d  = {1'b1, data};
            tx_d     = 1'b0;
        end
    end

    // Register the serialiser state; reset drops any byte in flight and
    // forces the line high on the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            clkCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            clkCnt_q <= clkCnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// -----------------------------------------------------------------------------
// reg_dump_tx
// On a start pulse, dumps the whole 32-entry register file over a UART: header
// byte 0xA5, then x0..x31 as 4 big-endian bytes each. With REG_DUMP_CHKSUM_EN
// defined, a final byte holding the XOR of all 128 payload bytes is appended.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   start    in   one-cycle dump request (ignored while busy and in FIN)
//   rd_addr  out  register-file read address (holds outside FETCH, 0 in IDLE)
//   rd_data  in   combinational read data for rd_addr
//   tx       out  UART line, 8N1, idle high
//   busy     out  dump in progress
//   done     out  one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module reg_dump_tx
    import reg_dump_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS - 1);
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REG);

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  byteCnt_q, byteCnt_d;
    logic [31:0] word_q, word_d;
    logic        load;
    logic [7:0]  loadData;
    logic        ready;
`ifdef REG_DUMP_CHKSUM_EN
    logic [7:0]  chk_q, chk_d;
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) uTx (
        .clk  (clk),
        .reset(reset),
        .load (load),
        .data (loadData),
        .tx   (tx),
        .ready(ready)
    );

    assign rd_addr = idx_q[4:0];
    assign busy    = (state_q != IDLE) && (state_q != FIN);
    assign done    = (state_q == FIN);

    // Sequencer. Every byte is loaded in the cycle the serialiser reports
    // ready (the last clock of the previous stop bit), so bytes run back to
    // back; the only gap is the single FETCH cycle before each register,
    // where the first byte is taken straight from rd_data.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        byteCnt_d = byteCnt_q;
        word_d    = word_q;
        load      = 1'b0;
        loadData  = 8'h00;
`ifdef REG_DUMP_CHKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    loadData  = HDR_BYTE;
                    idx_d     = '0;
                    byteCnt_d = '0;
`ifdef REG_DUMP_CHKSUM_EN
                    chk_d     = '0;
`endif
                    state_d   = HDR;
                end
            end
            HDR: begin
                if (ready) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                load      = 1'b1;
                loadData  = rd_data[31:24];
                word_d    = {rd_data[23:0], 8'h00};
                byteCnt_d = 3'd1;
`ifdef REG_DUMP_CHKSUM_EN
                chk_d     = chk_q ^ rd_data[31:24];
`endif
                state_d   = SEND;
            end
            SEND: begin
                if (ready) begin
                    if (byteCnt_q != LAST_BYTE) begin
                        load      = 1'b1;
                        loadData  = word_q[31:24];
                        word_d    = {word_q[23:0], 8'h00};
                        byteCnt_d = byteCnt_q + 3'd1;
`ifdef REG_DUMP_CHKSUM_EN
                        chk_d     = chk_q ^ word_q[31:24];
`endif
                    end else if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CHKSUM_EN
                        load     = 1'b1;
                        loadData = chk_q;
                        state_d  = CHK;
`else
                        state_d  = FIN;
`endif
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = FETCH;
                    end
                end
            end
`ifdef REG_DUMP_CHKSUM_EN
            CHK: begin
                if (ready) begin
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            byteCnt_q <= '0;
            word_q    <= '0;
`ifdef REG_DUMP_CHKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            byteCnt_q <= byteCnt_d;
            word_q    <= word_d;
`ifdef REG_DUMP_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_reg_dump_tx.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_tx
// Directed bench for reg_dump_tx with CLKS_PER_BIT=4 (40 clocks per byte).
// A bench-side UART receiver decodes tx; a register-file model answers reads.
// Honours REG_DUMP_CHKSUM_EN for frame length, latency and checksum byte.
// -----------------------------------------------------------------------------
module tb_reg_dump_tx;

    localparam int CPB = 4;
`ifdef REG_DUMP_CHKSUM_EN
    localparam int FRAME_BYTES = 130;
`else
    localparam int FRAME_BYTES = 129;
`endif
    // 40 clocks per byte plus one idle FETCH clock per register.
    localparam int DONE_LATENCY = FRAME_BYTES * 40 + 32;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          checkCount = 0;
    int          passCount  = 0;
    int          cycle      = 0;
    int          doneCount  = 0;
    logic [4:0]  rdAddrAtDone = '0;
    logic [7:0]  rxBytes [$];
    logic [7:0]  rxByte;
    int          stopErrs   = 0;

    reg_dump_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    assign rd_data = regs[rd_addr];

    always @(posedge clk) cycle <= cycle + 1;

    // Count every done pulse and remember where rd_addr was parked.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            doneCount    <= doneCount + 1;
            rdAddrAtDone <= rd_addr;
        end
    end

    // Receiver: detect the start bit, sample each bit mid-period.
    always begin
        @(negedge clk);
        if (tx === 1'b0 && reset === 1'b0) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                rxByte[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) stopErrs++;
            rxBytes.push_back(rxByte);
        end
    end

    function automatic logic [7:0] expByte(input int k);
        logic [31:0] w;
        logic [7:0]  c;
        if (k == 0) return 8'hA5;
        if (k <= 128) begin
            w = regs[(k - 1) / 4];
            return w[8 * (3 - ((k - 1) % 4)) +: 8];
        end
        c = 8'h00;
        for (int r = 0; r < 32; r++) begin
            w = regs[r];
            c = c ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
        end
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    endtask

    // Drive start/reset for exactly one sampling edge; called just after a
    // negedge, returns on the negedge following that edge.
    task automatic applyStimulus(input logic doStart, input logic doReset);
        start = doStart;
        reset = doReset;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit seen, output int at);
        seen = 1'b0;
        at   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                at   = cycle;
                break;
            end
        end
    endtask

    task automatic checkFrame(input string tag, input int base, input int stopBase);
        int mism;
        mism = 0;
        checkOutput({tag, "_len"}, rxBytes.size() - base, FRAME_BYTES);
        for (int k = 0; k < FRAME_BYTES; k++) begin
            if (base + k >= rxBytes.size()) mism++;
            else if (rxBytes[base + k] !== expByte(k)) mism++;
        end
        checkOutput({tag, "_mismatches"}, mism, 0);
        checkOutput({tag, "_stopErrs"}, stopErrs - stopBase, 0);
        checkOutput({tag, "_hdr"}, (base < rxBytes.size()) ? rxBytes[base] : 8'h00, 8'hA5);
    endtask

    initial begin
        int  startCycle;
        int  doneAt;
        int  lowCycles;
        int  rxBase;
        int  stopBase;
        int  doneBase;
        bit  seen;

        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        regs[1] = 32'h12345678;
        regs[5] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", tx, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_rdAddr", rd_addr, 5'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: start bit timing, a stray start during byte 10, full frame
        rxBase   = rxBytes.size();
        stopBase = stopErrs;
        applyStimulus(1'b1, 1'b0);
        startCycle = cycle;
        checkOutput("start_busy", busy, 1'b1);
        lowCycles = 0;
        for (int i = 0; i < 5; i++) begin
            if (tx === 1'b0) lowCycles++;
            @(negedge clk);
        end
        checkOutput("start_bitLen", lowCycles, 4);
        // Byte 10 occupies roughly clocks 403..442 after start.
        repeat (415) @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        checkOutput("stray_busy", busy, 1'b1);

        waitDone(7000, seen, doneAt);
        checkOutput("f1_doneSeen", seen, 1'b1);
        checkOutput("f1_latency", doneAt - startCycle, DONE_LATENCY);
        @(negedge clk);
        checkOutput("f1_busyAfter", busy, 1'b0);
        checkOutput("f1_doneOnce", done, 1'b0);
        repeat (60) @(negedge clk);
        checkOutput("f1_doneCount", doneCount, 1);
        checkOutput("f1_rdAddrAtDone", rdAddrAtDone, 5'd31);
        checkOutput("f1_rdAddrIdle", rd_addr, 5'd0);
        checkFrame("f1", rxBase, stopBase);
        checkOutput("x1_b0", rxBytes[rxBase + 5], 8'h12);
        checkOutput("x1_b1", rxBytes[rxBase + 6], 8'h34);
        checkOutput("x1_b2", rxBytes[rxBase + 7], 8'h56);
        checkOutput("x1_b3", rxBytes[rxBase + 8], 8'h78);
        checkOutput("x5_b0", rxBytes[rxBase + 21], 8'hDE);
        checkOutput("x5_b1", rxBytes[rxBase + 22], 8'hAD);
        checkOutput("x5_b2", rxBytes[rxBase + 23], 8'hBE);
        checkOutput("x5_b3", rxBytes[rxBase + 24], 8'hEF);
`ifdef REG_DUMP_CHKSUM_EN
        // XOR of the eight non-zero payload bytes works out to 0x2A.
        checkOutput("chksum", rxBytes[rxBase + 129],
                    8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif

        // Frame 2: reset during byte 50 abandons the frame
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0);
        // Byte 50 occupies roughly clocks 2013..2052 after start.
        repeat (2020) @(negedge clk);
        applyStimulus(1'b0, 1'b1);
        checkOutput("midRst_tx", tx, 1'b1);
        checkOutput("midRst_busy", busy, 1'b0);
        checkOutput("midRst_done", done, 1'b0);
        checkOutput("midRst_rdAddr", rd_addr, 5'd0);
        repeat (60) @(negedge clk);
        checkOutput("midRst_noDone", doneCount - doneBase, 0);
        checkOutput("midRst_txIdle", tx, 1'b1);

        // Frame 3: a fresh start after reset yields a complete frame
        rxBase   = rxBytes.size();
        stopBase = stopErrs;
        doneBase = doneCount;
        applyStimulus(1'b1, 1'b0);
        startCycle = cycle;
        checkOutput("f3_startBit", tx, 1'b0);
        waitDone(7000, seen, doneAt);
        checkOutput("f3_doneSeen", seen, 1'b1);
        checkOutput("f3_latency", doneAt - startCycle, DONE_LATENCY);
        repeat (60) @(negedge clk);
        checkOutput("f3_doneCount", doneCount - doneBase, 1);
        checkFrame("f3", rxBase, stopBase);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
